// File: rtl/partition_sweep_pkg.sv
// Shared types and width helpers for the partition sweep controller.
package partition_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      SAMPLE = 3'd2,
      REPORT = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Settle counter width; SETTLE is limited to 1..255.
   localparam int unsigned CNT_W = 8;

   // Smallest r with 2**r >= v.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   // Error counter: holds up to 2**n_in patterns.
   function automatic int unsigned err_w(input int unsigned n_in);
      return n_in + 1;
   endfunction

   // Hamming sum: holds up to n_out * 2**n_in.
   function automatic int unsigned sum_w(input int unsigned n_in, input int unsigned n_out);
      return n_in + 1 + clog2(n_out);
   endfunction

   // Popcount / Hamming max: holds values 0..n_out.
   function automatic int unsigned max_w(input int unsigned n_out);
      return clog2(n_out + 1);
   endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of an N_OUT-bit vector.
module popcount_n
   import partition_sweep_pkg::*;
#(
   parameter int unsigned N_OUT = 4
) (
   input  logic [N_OUT-1:0]        vec_i,
   output logic [max_w(N_OUT)-1:0] cnt_c
);

   localparam int unsigned CW = max_w(N_OUT);

   // Sum the individual bits.
   always_comb begin
      cnt_c = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         cnt_c = cnt_c + CW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive pattern sweep comparing an exact and an approximate partition,
// emitting per-pattern diff records and accumulating error statistics.
module partition_sweep_ctrl
   import partition_sweep_pkg::*;
#(
   parameter int unsigned N_IN   = 7,
   parameter int unsigned N_OUT  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           abort,
   output logic [N_IN-1:0]                pi_o,
   input  logic [N_OUT-1:0]               po_exact_i,
   input  logic [N_OUT-1:0]               po_approx_i,
   output logic                           rec_valid_o,
   input  logic                           rec_ready_i,
   output logic [N_IN-1:0]                rec_pat_o,
   output logic [N_OUT-1:0]               rec_diff_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [err_w(N_IN)-1:0]         err_cnt_o,
   output logic [sum_w(N_IN, N_OUT)-1:0]  ham_sum_o,
   output logic [max_w(N_OUT)-1:0]        ham_max_o
);

   localparam int unsigned EW = err_w(N_IN);
   localparam int unsigned SW = sum_w(N_IN, N_OUT);
   localparam int unsigned MW = max_w(N_OUT);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_IN-1:0]    pi_q, pi_d;
   logic [N_IN-1:0]    rec_pat_q, rec_pat_d;
   logic [N_OUT-1:0]   rec_diff_q, rec_diff_d;
   logic               rec_valid_q, rec_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [EW-1:0]      err_q, err_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic [MW-1:0]      max_q, max_d;

   logic [N_OUT-1:0]   diff_c;
   logic [MW-1:0]      pop_c;
   logic               xfer_c;

   assign diff_c = po_exact_i ^ po_approx_i;
   assign xfer_c = rec_valid_q & rec_ready_i;

   popcount_n #(.N_OUT(N_OUT)) u_pop (
      .vec_i (diff_c),
      .cnt_c (pop_c)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pi_d       = pi_q;
      rec_pat_d  = rec_pat_q;
      rec_diff_d = rec_diff_q;
      err_d      = err_q;
      sum_d      = sum_q;
      max_d      = max_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT;
               pi_d    = '0;
               err_d   = '0;
               sum_d   = '0;
               max_d   = '0;
               cnt_d   = CNT_W'(SETTLE);
            end
         end
         WAIT: begin
            if (cnt_q <= CNT_W'(1)) state_d = SAMPLE;
            else                    cnt_d   = cnt_q - CNT_W'(1);
         end
         SAMPLE: begin
            rec_diff_d = diff_c;
            rec_pat_d  = pi_q;
            sum_d      = sum_q + SW'(pop_c);
            if (diff_c != '0) err_d = err_q + EW'(1);
            if (pop_c > max_q) max_d = pop_c;
            state_d    = REPORT;
         end
         REPORT: begin
            if (xfer_c) begin
               if (pi_q == '1) begin
                  state_d = DONE;
               end else begin
                  pi_d    = pi_q + N_IN'(1);
                  cnt_d   = CNT_W'(SETTLE);
                  state_d = WAIT;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort wins over any transition once a sweep is running.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         pi_d    = '0;
      end

      rec_valid_d = (state_d == REPORT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pi_q        <= '0;
         rec_pat_q   <= '0;
         rec_diff_q  <= '0;
         rec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
         sum_q       <= '0;
         max_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pi_q        <= pi_d;
         rec_pat_q   <= rec_pat_d;
         rec_diff_q  <= rec_diff_d;
         rec_valid_q <= rec_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         sum_q       <= sum_d;
         max_q       <= max_d;
      end
   end

   assign pi_o        = pi_q;
   assign rec_pat_o   = rec_pat_q;
   assign rec_diff_o  = rec_diff_q;
   assign rec_valid_o = rec_valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_cnt_o   = err_q;
   assign ham_sum_o   = sum_q;
   assign ham_max_o   = max_q;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Directed/randomized bench for partition_sweep_ctrl with a lookup-table partition model.
module tb_partition_sweep_ctrl;

   localparam int NPAT = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, rec_ready;
   logic [6:0] pi, rec_pat;
   logic [3:0] po_ex, po_ap, rec_diff;
   logic       rec_valid, busy, done;
   logic [7:0] err;
   logic [9:0] hsum;
   logic [2:0] hmax;

   logic       start3, abort3, rec_ready3;
   logic [6:0] pi3, rec_pat3;
   logic [3:0] po_ex3, po_ap3, rec_diff3;
   logic       rec_valid3, busy3, done3;
   logic [7:0] err3;
   logic [9:0] hsum3;
   logic [2:0] hmax3;

   logic [3:0] ex_lut [NPAT];
   logic [3:0] ap_lut [NPAT];

   assign po_ex  = ex_lut[pi];
   assign po_ap  = ap_lut[pi];
   assign po_ex3 = ex_lut[pi3];
   assign po_ap3 = ap_lut[pi3];

   partition_sweep_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pi_o(pi),
      .po_exact_i(po_ex), .po_approx_i(po_ap), .rec_valid_o(rec_valid),
      .rec_ready_i(rec_ready), .rec_pat_o(rec_pat), .rec_diff_o(rec_diff),
      .busy_o(busy), .done_o(done), .err_cnt_o(err), .ham_sum_o(hsum), .ham_max_o(hmax)
   );

   partition_sweep_ctrl #(.N_IN(7), .N_OUT(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .pi_o(pi3),
      .po_exact_i(po_ex3), .po_approx_i(po_ap3), .rec_valid_o(rec_valid3),
      .rec_ready_i(rec_ready3), .rec_pat_o(rec_pat3), .rec_diff_o(rec_diff3),
      .busy_o(busy3), .done_o(done3), .err_cnt_o(err3), .ham_sum_o(hsum3), .ham_max_o(hmax3)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Partition behaviour: 0 identity, 1 approx stuck at zero, 2 random sparse faults.
   task automatic load_luts(input int mode);
      for (int p = 0; p < NPAT; p++) begin
         logic [6:0] pv;
         logic [3:0] r;
         pv = 7'(p);
         case (mode)
            0: begin ex_lut[p] = pv[3:0]; ap_lut[p] = pv[3:0]; end
            1: begin ex_lut[p] = pv[3:0]; ap_lut[p] = 4'h0;    end
            default: begin
               r = 4'($urandom);
               ex_lut[p] = r;
               ap_lut[p] = ($urandom_range(0, 2) == 0) ? (r ^ 4'($urandom)) : r;
            end
         endcase
      end
   endtask

   // Expected statistics over patterns 0..last.
   task automatic model(input int last, output int e, output int s, output int m);
      e = 0; s = 0; m = 0;
      for (int p = 0; p <= last; p++) begin
         int c;
         c = $countones(ex_lut[p] ^ ap_lut[p]);
         s += c;
         if (c != 0) e++;
         if (c > m) m = c;
      end
   endtask

   task automatic check_totals(input string tag, input int last);
      int e, s, m;
      model(last, e, s, m);
      check({tag, "_err"},  64'(err),  64'(e));
      check({tag, "_hsum"}, 64'(hsum), 64'(s));
      check({tag, "_hmax"}, 64'(hmax), 64'(m));
   endtask

   // Start a sweep and follow it; returns early at the REPORT of stop_pat (at a negedge).
   task automatic run_sweep(input string tag, input int stop_pat, input int stall_pat,
                            input bit rand_ready, input bit start_noise, input bit with_abort,
                            input int exp_cyc);
      int cyc, nrec, stall_left;
      bit got_done, v;
      logic [6:0] p, pp;
      logic [3:0] d;
      @(negedge clk);
      start = 1'b1; abort = with_abort; rec_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      cyc = 1; nrec = 0; stall_left = 5; got_done = 1'b0;
      check({tag, "_busy_start"}, 64'(busy), 64'(1));
      check({tag, "_pi_start"},   64'(pi),   64'(0));
      check({tag, "_clr_err"},    64'(err),  64'(0));
      check({tag, "_clr_hsum"},   64'(hsum), 64'(0));
      check({tag, "_clr_hmax"},   64'(hmax), 64'(0));
      for (int k = 0; k < 3000 && !got_done; k++) begin
         @(negedge clk);
         v = rec_valid; p = rec_pat; d = rec_diff; pp = pi;
         if (stop_pat >= 0 && v && int'(p) == stop_pat) return;
         start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (v && int'(p) == stall_pat && stall_left > 0) begin
            rec_ready = 1'b0;
            stall_left--;
         end else begin
            rec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
         if (v && !rec_ready) begin
            check({tag, "_stall_valid"}, 64'(rec_valid), 64'(1));
            check({tag, "_stall_pat"},   64'(rec_pat),   64'(p));
            check({tag, "_stall_diff"},  64'(rec_diff),  64'(d));
            check({tag, "_stall_pi"},    64'(pi),        64'(pp));
         end
         if (v && rec_ready) begin
            check({tag, "_rec_pat"},  64'(p), 64'(nrec));
            check({tag, "_rec_diff"}, 64'(d), 64'(ex_lut[nrec] ^ ap_lut[nrec]));
            nrec++;
         end
         if (done) got_done = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; rec_ready = 1'b1;
      check({tag, "_done_seen"}, 64'(got_done), 64'(1));
      check({tag, "_nrec"},      64'(nrec),     64'(NPAT));
      if (exp_cyc > 0) check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      check_totals(tag, NPAT - 1);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_idle"},       64'(busy), 64'(0));
   endtask

   initial begin
      int e, s, m, cyc, age, nrec;
      bit got, was_valid;
      logic [6:0] prev;

      rst = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b1;
      start3 = 1'b0; abort3 = 1'b0; rec_ready3 = 1'b1;
      load_luts(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_pi",    64'(pi),        64'(0));
      check("rst_pat",   64'(rec_pat),   64'(0));
      check("rst_diff",  64'(rec_diff),  64'(0));
      check("rst_valid", 64'(rec_valid), 64'(0));
      check("rst_busy",  64'(busy),      64'(0));
      check("rst_done",  64'(done),      64'(0));
      check("rst_err",   64'(err),       64'(0));
      check("rst_hsum",  64'(hsum),      64'(0));
      check("rst_hmax",  64'(hmax),      64'(0));
      check("rst_busy3", 64'(busy3),     64'(0));
      @(negedge clk); rst = 1'b0;

      // Abort alone in IDLE does nothing.
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1;
      check("idle_abort_busy", 64'(busy), 64'(0));
      @(negedge clk); abort = 1'b0;

      // Identity partition.
      load_luts(0);
      run_sweep("ident", -1, -1, 1'b0, 1'b0, 1'b0, 385);
      check("ident_err_k",  64'(err),  64'(0));
      check("ident_hsum_k", 64'(hsum), 64'(0));
      check("ident_hmax_k", 64'(hmax), 64'(0));

      // Approx stuck at zero.
      load_luts(1);
      run_sweep("stuck", -1, -1, 1'b0, 1'b0, 1'b0, 385);
      check("stuck_err_k",  64'(err),  64'(120));
      check("stuck_hsum_k", 64'(hsum), 64'(256));
      check("stuck_hmax_k", 64'(hmax), 64'(4));
      repeat (4) @(posedge clk);
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("hold_busy", 64'(busy), 64'(0));
      check("hold_err",  64'(err),  64'(120));
      check("hold_hsum", 64'(hsum), 64'(256));
      check("hold_hmax", 64'(hmax), 64'(4));

      // Backpressure at pattern 10 on random data.
      load_luts(2);
      run_sweep("stall", -1, 10, 1'b0, 1'b0, 1'b0, 390);

      // Random ready, start noise while busy, abort together with start.
      run_sweep("noise", -1, -1, 1'b1, 1'b1, 1'b1, 0);

      // Abort in REPORT of pattern 40.
      run_sweep("abort", 40, -1, 1'b0, 1'b0, 1'b0, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy",  64'(busy),      64'(0));
      check("abort_valid", 64'(rec_valid), 64'(0));
      check("abort_pi",    64'(pi),        64'(0));
      check("abort_done",  64'(done),      64'(0));
      check_totals("abort", 40);
      got = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) got = 1'b1;
      end
      check("abort_no_done", 64'(got), 64'(0));
      run_sweep("restart", -1, -1, 1'b0, 1'b0, 1'b0, 385);

      // Reset in REPORT of pattern 70.
      run_sweep("rstmid", 70, -1, 1'b0, 1'b0, 1'b0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_pi",    64'(pi),        64'(0));
      check("arst_valid", 64'(rec_valid), 64'(0));
      check("arst_busy",  64'(busy),      64'(0));
      check("arst_done",  64'(done),      64'(0));
      check("arst_pat",   64'(rec_pat),   64'(0));
      check("arst_diff",  64'(rec_diff),  64'(0));
      check("arst_err",   64'(err),       64'(0));
      check("arst_hsum",  64'(hsum),      64'(0));
      check("arst_hmax",  64'(hmax),      64'(0));
      @(negedge clk); rst = 1'b0;
      got = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (busy || done) got = 1'b1;
      end
      check("post_rst_quiet", 64'(got), 64'(0));
      run_sweep("post_rst", -1, -1, 1'b0, 1'b1, 1'b0, 385);

      // SETTLE = 3 instance.
      load_luts(2);
      @(negedge clk); start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      cyc = 1; age = 0; prev = pi3; nrec = 0; got = 1'b0; was_valid = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (pi3 != prev) age = 0;
         else             age++;
         prev = pi3;
         if (rec_valid3 && !was_valid) begin
            check("s3_settle_age", 64'(age),      64'(4));
            check("s3_rec_pat",    64'(rec_pat3), 64'(nrec));
            check("s3_rec_diff",   64'(rec_diff3), 64'(ex_lut[nrec] ^ ap_lut[nrec]));
            nrec++;
         end
         was_valid = rec_valid3;
         if (done3) got = 1'b1;
      end
      check("s3_done_seen",  64'(got),  64'(1));
      check("s3_done_cycle", 64'(cyc),  64'(641));
      check("s3_nrec",       64'(nrec), 64'(NPAT));
      model(NPAT - 1, e, s, m);
      check("s3_err",  64'(err3),  64'(e));
      check("s3_hsum", 64'(hsum3), 64'(s));
      check("s3_hmax", 64'(hmax3), 64'(m));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/partition_sweep_ctrl.md
PARTITION_SWEEP_CTRL -- requirements
Module: partition_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter N_IN, default 7, meaning partition input width.
REQ-002 The block SHALL have parameter N_OUT, default 4, meaning partition output width.
REQ-003 The block SHALL have parameter SETTLE, default 1, meaning cycles each pattern is held before sampling; legal values are 1 to 255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel a sweep.
REQ-008 The block SHALL have port pi_o, output, N_IN bits: pattern driven to both partitions.
REQ-009 The block SHALL have port po_exact_i, input, N_OUT bits: exact partition output.
REQ-010 The block SHALL have port po_approx_i, input, N_OUT bits: approximate partition output.
REQ-011 The block SHALL have port rec_valid_o, output, 1 bit: per-pattern record valid.
REQ-012 The block SHALL have port rec_ready_i, input, 1 bit: record consumer ready.
REQ-013 The block SHALL have port rec_pat_o, output, N_IN bits: pattern of the current record.
REQ-014 The block SHALL have port rec_diff_o, output, N_OUT bits: exact XOR approx for that pattern.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-017 The block SHALL have port err_cnt_o, output, N_IN+1 bits: count of patterns with a nonzero diff.
REQ-018 The block SHALL have port ham_sum_o, output, N_IN+1+clog2(N_OUT) bits: sum of popcount(diff) over all patterns.
REQ-019 The block SHALL have port ham_max_o, output, clog2(N_OUT+1) bits: maximum popcount(diff) seen.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT, SAMPLE, REPORT and DONE.
REQ-021 When start is high in IDLE, the block SHALL set pi_o=0, clear err_cnt_o, ham_sum_o and ham_max_o, load the settle counter with SETTLE, and go to WAIT.
REQ-022 WAIT SHALL last exactly SETTLE cycles with pi_o stable, then go to SAMPLE.
REQ-023 SAMPLE SHALL last one cycle and SHALL register diff = po_exact_i ^ po_approx_i into rec_diff_o and pi_o into rec_pat_o.
REQ-024 In the same SAMPLE edge the block SHALL add popcount(diff) to ham_sum_o, SHALL increment err_cnt_o if diff is nonzero, and SHALL update ham_max_o; the block then goes to REPORT.
REQ-025 In REPORT rec_valid_o SHALL be high, and rec_pat_o and rec_diff_o SHALL stay stable until the cycle in which rec_valid_o and rec_ready_i are both high (the transfer cycle).
REQ-026 On the transfer cycle, if pi_o equals all ones the block SHALL go to DONE; otherwise pi_o SHALL increment by 1 and the block SHALL go to WAIT with the counter reloaded.
REQ-027 In DONE, done_o SHALL be high for exactly one cycle, after which the block SHALL go to IDLE.
REQ-028 Accumulators SHALL hold their values in IDLE until the next accepted start.
REQ-029 With rec_ready_i tied high, done_o SHALL assert (SETTLE+2)*2^N_IN+1 cycles after the start edge; for the defaults this is 385 cycles.
REQ-030 start SHALL be ignored while busy_o is high.
REQ-031 abort SHALL take priority over every transition: the next state is IDLE, pi_o is set to 0, rec_valid_o to 0, done_o is not pulsed, and the accumulators hold their partial values.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 If abort and start are both high in IDLE, the sweep SHALL start.
REQ-034 Accumulators SHALL NOT overflow at their specified widths; the maximum ham_sum_o is N_OUT*2^N_IN.
REQ-035 pi_o SHALL NOT wrap from all ones back to 0 within a sweep.

Reset
REQ-036 While rst is high, the block SHALL be in IDLE with pi_o, rec_pat_o, rec_diff_o, err_cnt_o, ham_sum_o and ham_max_o all 0, and rec_valid_o, busy_o and done_o all 0.
REQ-037 Reset asserted mid-sweep SHALL abandon the sweep immediately, with no done_o pulse; after reset deasserts, only a new start resumes activity.

Structure
REQ-038 A package partition_sweep_pkg SHALL hold the FSM state enum and the width helper functions (clog2 and the accumulator widths).
REQ-039 A combinational sub-module popcount_n, parameterised by N_OUT, SHALL compute popcount(diff); the controller SHALL instantiate it once.

Verification
REQ-040 Identity: with po_approx_i = po_exact_i = pi_o[3:0], defaults, ready high -> done_o at cycle 385, err_cnt_o=0, ham_sum_o=0, ham_max_o=0, and 128 records with pattern 0..127 in order.
REQ-041 Stuck-zero: with po_exact_i = pi_o[3:0] and po_approx_i = 0 -> err_cnt_o=120, ham_sum_o=256, ham_max_o=4.
REQ-042 Backpressure: rec_ready_i low for 5 cycles at pattern 10 -> rec_valid_o held high, rec_pat_o=10 and pi_o=10 stable throughout, and final totals equal to the no-stall run.
REQ-043 Abort: abort pulsed in the REPORT state of pattern 40 -> IDLE next cycle, no done_o, err_cnt_o equals the count for patterns 0..40; a following start clears the accumulators and begins again from 0.
REQ-044 Reset mid-sweep: rst asserted at pattern 70 -> all outputs 0 asynchronously; start while busy_o is high -> ignored, and sweep length is unchanged.
REQ-045 SETTLE=3: done_o SHALL assert at cycle 641, and no sample SHALL occur before pi_o has been stable for 3 cycles.
